// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared types and limits for the APB master arbiter.
//   arb_state_e : arbiter FSM states
//   ARB_MAX_REQ : largest supported requester count
package apb_arb_pkg;

   localparam int unsigned ARB_MAX_REQ = 4;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StSetup,
      StAccess,
      StDone
   } arb_state_e;

endpackage

// File: rtl/apb_master_arbiter_if.sv
// apb_master_arbiter_if: requester-side and master-side signals of the APB master arbiter.
//   req_valid/req_addr/req_wdata/req_write : per-requester command, packed
//   req_done/req_rdata                     : one-hot completion pulse and read data
//   grant/busy                             : current owner and activity flag
//   m_transfer/m_addr/m_wdata/m_write      : command towards the APB master
//   m_rdata/m_ready                        : response from the APB master
// Modports:
//   slave  : the arbiter (serves requesters, drives the APB master command)
//   master : the environment (requesters plus APB master)
interface apb_master_arbiter_if #(
   parameter int unsigned NUM_REQ = 2
);

   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ*32-1:0] req_addr;
   logic [NUM_REQ*32-1:0] req_wdata;
   logic [NUM_REQ-1:0]    req_write;
   logic [NUM_REQ-1:0]    req_done;
   logic [31:0]           req_rdata;
   logic [NUM_REQ-1:0]    grant;
   logic                  busy;
   logic                  m_transfer;
   logic [31:0]           m_addr;
   logic [31:0]           m_wdata;
   logic                  m_write;
   logic [31:0]           m_rdata;
   logic                  m_ready;

   modport slave (
      input  req_valid, req_addr, req_wdata, req_write, m_rdata, m_ready,
      output req_done, req_rdata, grant, busy, m_transfer, m_addr, m_wdata, m_write
   );

   modport master (
      output req_valid, req_addr, req_wdata, req_write, m_rdata, m_ready,
      input  req_done, req_rdata, grant, busy, m_transfer, m_addr, m_wdata, m_write
   );

endinterface

// File: rtl/apb_rr_picker.sv
// apb_rr_picker: combinational winner selection among pending requests.
//   req_i : pending request per requester
//   ptr_i : round-robin search start index
//   gnt_o : one-hot winner (0 when nothing pending)
//   idx_o : binary index of the winner
// Macro APB_ARB_FIXED_PRIO_EN: lowest index wins and ptr_i is ignored.
module apb_rr_picker #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned PTR_W   = 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [PTR_W-1:0]   idx_o
);

`ifdef APB_ARB_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr_i;
`endif

   // Walk offsets from farthest to nearest so the last hit (nearest to the
   // search start) is the one that sticks.
   always_comb begin
      int               j;
      logic [PTR_W-1:0] sel;
      gnt_o = '0;
      idx_o = '0;
      j     = 0;
      sel   = '0;
      for (int off = int'(NUM_REQ) - 1; off >= 0; off--) begin
`ifdef APB_ARB_FIXED_PRIO_EN
         j = off;
`else
         j = int'(ptr_i) + off;
         if (j >= int'(NUM_REQ)) begin
            j = j - int'(NUM_REQ);
         end
`endif
         sel = PTR_W'(j);
         if (req_i[sel]) begin
            gnt_o      = '0;
            gnt_o[sel] = 1'b1;
            idx_o      = sel;
         end
      end
   end

endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares the APB master request port among NUM_REQ requesters.
//   PCLK    : clock
//   PRESETn : asynchronous active-low reset
//   bus     : apb_master_arbiter_if.slave (requests, completions, master command/response)
// One transfer at a time: IDLE -> ISSUE -> SETUP -> ACCESS (until m_ready) -> DONE.
// Macro APB_ARB_FIXED_PRIO_EN: fixed priority (lowest index), no pointer register;
// default build uses round robin.
module apb_master_arbiter
   import apb_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2
) (
   input  logic                 PCLK,
   input  logic                 PRESETn,
   apb_master_arbiter_if.slave  bus
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if (NUM_REQ < 2 || NUM_REQ > ARB_MAX_REQ) begin : g_bad_num_req
      $error("apb_master_arbiter: NUM_REQ must be between 2 and %0d", ARB_MAX_REQ);
   end

   arb_state_e          state_q, state_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic [31:0]         addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                write_q, write_d;
   logic [31:0]         rdata_q, rdata_d;
   logic [NUM_REQ-1:0]  pick_gnt;
   logic [PTR_W-1:0]    pick_idx;
   logic [PTR_W-1:0]    pick_ptr;
   logic                arb_win;

   // Arbitration happens only in IDLE; requests arriving later wait in place.
   assign arb_win = (state_q == StIdle) && (|bus.req_valid);

`ifdef APB_ARB_FIXED_PRIO_EN
   logic unused_idx;
   assign unused_idx = ^pick_idx;
   assign pick_ptr   = '0;
`else
   logic [PTR_W-1:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (arb_win) begin
         ptr_d = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign pick_ptr = ptr_q;
`endif

   apb_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_picker (
      .req_i (bus.req_valid),
      .ptr_i (pick_ptr),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx)
   );

   // State register
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; m_ready is deliberately ignored in SETUP since slave
   // PREADY may already be high before PENABLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (|bus.req_valid) state_d = StIssue;
         StIssue:  state_d = StSetup;
         StSetup:  state_d = StAccess;
         StAccess: if (bus.m_ready) state_d = StDone;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Grant, command latch and read-data capture
   always_comb begin
      gnt_d   = gnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      write_d = write_q;
      rdata_d = rdata_q;
      if (arb_win) begin
         gnt_d = pick_gnt;
         for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (pick_gnt[k]) begin
               addr_d  = bus.req_addr[k*32 +: 32];
               wdata_d = bus.req_wdata[k*32 +: 32];
               write_d = bus.req_write[k];
            end
         end
      end
      if (state_q == StAccess && bus.m_ready) begin
         rdata_d = write_q ? 32'h0 : bus.m_rdata;
      end
      if (state_q == StDone) begin
         gnt_d = '0;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         gnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         gnt_q   <= gnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         write_q <= write_d;
         rdata_q <= rdata_d;
      end
   end

   // Outputs decoded from registered state only
   always_comb begin
      bus.busy       = (state_q != StIdle);
      bus.m_transfer = (state_q == StIssue);
      bus.req_done   = (state_q == StDone) ? gnt_q : '0;
      bus.grant      = gnt_q;
      bus.req_rdata  = rdata_q;
      bus.m_addr     = addr_q;
      bus.m_wdata    = wdata_q;
      bus.m_write    = write_q;
   end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed and randomized checks of apb_master_arbiter with
// four requesters against a transaction-level model (pending set + search pointer).
module tb_apb_master_arbiter;

   localparam int NR = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   apb_master_arbiter_if #(.NUM_REQ(NR)) bus ();

   apb_master_arbiter #(
      .NUM_REQ (NR)
   ) u_dut (
      .PCLK    (clk),
      .PRESETn (rst_n),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int          ptr = 0;
   bit          pend    [NR];
   logic [31:0] r_addr  [NR];
   logic [31:0] r_wdata [NR];
   bit          r_write [NR];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick();
      for (int i = 0; i < NR; i++) begin
         int j;
`ifdef APB_ARB_FIXED_PRIO_EN
         j = i;
`else
         j = (ptr + i) % NR;
`endif
         if (pend[j]) return j;
      end
      return -1;
   endfunction

   task automatic drive_valid();
      for (int k = 0; k < NR; k++) begin
         bus.req_valid[k]          = pend[k];
         bus.req_addr[k*32 +: 32]  = r_addr[k];
         bus.req_wdata[k*32 +: 32] = r_wdata[k];
         bus.req_write[k]          = r_write[k];
      end
   endtask

   task automatic new_req(input int k, input bit wr);
      pend[k]    = 1'b1;
      r_addr[k]  = $urandom;
      r_wdata[k] = $urandom;
      r_write[k] = wr;
   endtask

   task automatic clear_all();
      for (int k = 0; k < NR; k++) pend[k] = 1'b0;
      drive_valid();
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_grant"}, 32'(bus.grant), 32'h0);
      check_eq({tag, "_busy"}, 32'(bus.busy), 32'h0);
      check_eq({tag, "_done"}, 32'(bus.req_done), 32'h0);
      check_eq({tag, "_rdata"}, bus.req_rdata, 32'h0);
      check_eq({tag, "_xfer"}, 32'(bus.m_transfer), 32'h0);
      check_eq({tag, "_addr"}, bus.m_addr, 32'h0);
      check_eq({tag, "_wdata"}, bus.m_wdata, 32'h0);
      check_eq({tag, "_write"}, 32'(bus.m_write), 32'h0);
   endtask

   task automatic check_cmd(input string tag, input int w);
      check_eq({tag, "_grant"}, 32'(bus.grant), 32'(1 << w));
      check_eq({tag, "_addr"}, bus.m_addr, r_addr[w]);
      check_eq({tag, "_wdata"}, bus.m_wdata, r_wdata[w]);
      check_eq({tag, "_write"}, 32'(bus.m_write), 32'(r_write[w]));
   endtask

   // Called at the negedge of an IDLE cycle N with the pending set prepared.
   task automatic run_xfer(input int waits, input logic [31:0] rd, input bit rdy_setup,
                           input bit add_busy, output int got_idx);
      int win;
      got_idx = -1;
      win = pick();
      if (win < 0) begin
         check_eq("no_pending", 32'h0, 32'h1);
         return;
      end
      drive_valid();
      bus.m_ready = 1'b0;
`ifndef APB_ARB_FIXED_PRIO_EN
      ptr = (win + 1) % NR;
`endif
      @(negedge clk); // N+1: ISSUE
      check_eq("issue_xfer", 32'(bus.m_transfer), 32'h1);
      check_eq("issue_busy", 32'(bus.busy), 32'h1);
      check_eq("issue_done", 32'(bus.req_done), 32'h0);
      check_cmd("issue", win);
      for (int k = 0; k < NR; k++) if (bus.grant[k]) got_idx = k;
      if (add_busy) begin
         for (int k = 0; k < NR; k++) begin
            if (k != win && !pend[k] && $urandom_range(0, 2) == 0) new_req(k, 1'($urandom));
         end
         drive_valid();
      end
      @(negedge clk); // N+2: SETUP
      check_eq("setup_xfer", 32'(bus.m_transfer), 32'h0);
      check_eq("setup_done", 32'(bus.req_done), 32'h0);
      check_cmd("setup", win);
      bus.m_ready = rdy_setup;
      bus.m_rdata = $urandom;
      for (int c = 0; c <= waits; c++) begin
         @(negedge clk); // ACCESS
         check_eq("access_done", 32'(bus.req_done), 32'h0);
         check_eq("access_xfer", 32'(bus.m_transfer), 32'h0);
         check_cmd("access", win);
         bus.m_ready = (c == waits);
         bus.m_rdata = (c == waits) ? rd : $urandom;
      end
      @(negedge clk); // DONE
      bus.m_ready = 1'b0;
      check_eq("done_pulse", 32'(bus.req_done), 32'(1 << win));
      check_eq("done_rdata", bus.req_rdata, r_write[win] ? 32'h0 : rd);
      check_eq("done_busy", 32'(bus.busy), 32'h1);
      check_cmd("done", win);
      pend[win] = 1'b0;
      drive_valid();
      @(negedge clk); // back in IDLE
      check_eq("idle_done", 32'(bus.req_done), 32'h0);
      check_eq("idle_grant", 32'(bus.grant), 32'h0);
      check_eq("idle_busy", 32'(bus.busy), 32'h0);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      clear_all();
      bus.m_ready = 1'b0;
      ptr = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int idx;
      int exp;
      bus.m_ready = 1'b0;
      bus.m_rdata = '0;
      for (int k = 0; k < NR; k++) begin
         pend[k] = 1'b0; r_addr[k] = '0; r_wdata[k] = '0; r_write[k] = 1'b0;
      end
      drive_valid();
      repeat (3) @(negedge clk);
      check_all_zero("in_reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_all_zero("post_reset");

      // Single zero-wait read from requester 0
      pend[0] = 1'b1; r_addr[0] = 32'h1000_2004; r_wdata[0] = 32'h0; r_write[0] = 1'b0;
      run_xfer(0, 32'hDEAD_BEEF, 1'b0, 1'b0, idx);
      check_eq("single_idx", 32'(idx), 32'h0);

      // Requesters 0 and 1 held
      apply_reset();
      new_req(0, 1'b0);
      new_req(1, 1'b0);
      for (int t = 0; t < 4; t++) begin
         run_xfer(0, $urandom, 1'b0, 1'b0, idx);
`ifdef APB_ARB_FIXED_PRIO_EN
         exp = 0;
`else
         exp = t % 2;
`endif
         check_eq("alt_order", 32'(idx), 32'(exp));
         if (idx >= 0) pend[idx] = 1'b1;
      end
      clear_all();

      // Write from requester 1 with 3 wait states
      new_req(1, 1'b1);
      r_wdata[1] = 32'h1234_5678;
      run_xfer(3, 32'hCAFE_F00D, 1'b0, 1'b0, idx);
      check_eq("write_idx", 32'(idx), 32'h1);

      // m_ready high during SETUP must not complete early
      new_req(2, 1'b0);
      run_xfer(0, 32'hA5A5_0F0F, 1'b1, 1'b0, idx);
      check_eq("early_rdy_idx", 32'(idx), 32'h2);

      // Reset during ACCESS of a requester-0 read
      new_req(0, 1'b0);
      drive_valid();
      @(negedge clk); // ISSUE
      @(negedge clk); // SETUP
      bus.m_ready = 1'b0;
      @(negedge clk); // ACCESS
      rst_n = 1'b0;
      #1;
      check_all_zero("abort");
      clear_all();
      ptr = 0;
      @(negedge clk);
      check_eq("abort_done", 32'(bus.req_done), 32'h0);
      check_eq("abort_busy", 32'(bus.busy), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      new_req(0, 1'b0);
      new_req(1, 1'b1);
      run_xfer(1, $urandom, 1'b0, 1'b0, idx);
      check_eq("post_abort_idx", 32'(idx), 32'h0);
      run_xfer(0, $urandom, 1'b0, 1'b0, idx);
`ifdef APB_ARB_FIXED_PRIO_EN
      exp = 1; // requester 0 dropped after its done
`else
      exp = 1;
`endif
      check_eq("post_abort_idx2", 32'(idx), 32'(exp));
      clear_all();

      // All four held for 8 transfers
      apply_reset();
      for (int k = 0; k < NR; k++) new_req(k, 1'($urandom));
      for (int t = 0; t < 8; t++) begin
         run_xfer($urandom_range(0, 1), $urandom, 1'b0, 1'b0, idx);
`ifdef APB_ARB_FIXED_PRIO_EN
         exp = 0;
`else
         exp = t % NR;
`endif
         check_eq("wrap_order", 32'(idx), 32'(exp));
         if (idx >= 0) pend[idx] = 1'b1;
      end
      clear_all();

      // Randomized traffic with withdrawals and requests arriving while busy
      for (int t = 0; t < 40; t++) begin
         bit any;
         any = 1'b0;
         for (int k = 0; k < NR; k++) begin
            if (!pend[k] && $urandom_range(0, 1) == 0) new_req(k, 1'($urandom));
            else if (pend[k] && $urandom_range(0, 7) == 0) pend[k] = 1'b0;
            if (pend[k]) any = 1'b1;
         end
         if (!any) new_req($urandom_range(0, NR - 1), 1'($urandom));
         run_xfer($urandom_range(0, 3), $urandom, 1'($urandom), 1'b1, idx);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Shares the single internal request port of the APB master (transfer/addr/wdata/write in, rdata/ready out) among up to four requesters such as the CPU bus bridge and the DMA engine. It arbitrates pending requests, latches the winner's command, sequences one APB transfer through the master, and returns read data with a one-cycle completion pulse. It sits between the requesters and the APB master, on the PCLK domain.

## Interface
- NUM_REQ, default 2: number of requesters. Legal values are 2 to 4; any other value triggers an elaboration-time `$error`.
- PCLK, input, 1: clock.
- PRESETn, input, 1: asynchronous active-low reset.
- req_valid, input, NUM_REQ: request pending per requester. Held high, with its fields stable, until that requester's req_done.
- req_addr, input, NUM_REQ×32: per-requester address, packed.
- req_wdata, input, NUM_REQ×32: per-requester write data, packed.
- req_write, input, NUM_REQ: 1 = write, 0 = read.
- req_done, output, NUM_REQ: one-hot, one-cycle completion pulse.
- req_rdata, output, 32: completion data, valid while req_done is high.
- grant, output, NUM_REQ: one-hot owner of the current transfer; 0 when idle.
- busy, output, 1: high in every state except IDLE.
- m_transfer, output, 1: to master `transfer`.
- m_addr, output, 32: to master `addr`.
- m_wdata, output, 32: to master `wdata`.
- m_write, output, 1: to master `write`.
- m_rdata, input, 32: from master `rdata`.
- m_ready, input, 1: from master `ready`.

## Operation
- The FSM has five states: IDLE, ISSUE, SETUP, ACCESS, DONE.
- IDLE → ISSUE: when any req_valid is high.
  - Register the grant.
  - Latch the winner's addr, wdata and write into cmd registers.
  - Advance the round-robin pointer.
- ISSUE → SETUP, unconditionally.
  - m_transfer = 1 for exactly this cycle.
  - The master samples the command in its IDLE state.
- SETUP → ACCESS, unconditionally.
  - This cycle mirrors the master's SETUP phase.
  - m_ready is ignored here, because slave PREADY can be high before PENABLE.
- ACCESS → DONE: when m_ready is high.
  - Capture req_rdata = m_write_reg ? 0 : m_rdata.
  - Otherwise stay in ACCESS; there is no timeout.
- DONE → IDLE, unconditionally.
  - req_done[grant] = 1.
  - grant clears on the transition to IDLE.
- No arbitration happens in DONE. The requester drops req_valid at the end of its done cycle, and this prevents a stale re-grant.
- m_addr, m_wdata and m_write are driven from the cmd registers in every state, so they are stable across ISSUE through ACCESS.
- Round robin: search starts at the pointer. On a grant to index k, the pointer becomes (k+1) mod NUM_REQ and wraps from NUM_REQ-1 to 0.
- Requests that arrive while busy wait in place. They are never dropped.
- If a requester deasserts req_valid before it is granted, that is legal: the request is withdrawn. Deasserting after grant is a protocol violation and does not abort the transfer.

## Timing
- Reset values: state = IDLE, pointer = 0, and grant, busy, req_done, req_rdata, m_transfer, m_addr, m_wdata, m_write all 0.
- Reset mid-transfer returns everything to those values immediately. No req_done is issued for the aborted transfer.
- Latency for zero-wait-state slaves: req_valid high in cycle N (IDLE) gives ISSUE at N+1, SETUP at N+2, ACCESS at N+3 and req_done at N+4. Each slave wait cycle adds one cycle.
- Minimum spacing between grants is 5 cycles.
- All outputs are registered or decoded from registered state only. There are no combinational input-to-output paths.

## Configuration
- `APB_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority, where the lowest index wins. The pointer register is not instantiated.
  - Undefined (default): round robin as specified in Operation.

## Structure
- apb_arb_pkg holds:
  - the `arb_state_e` enum (IDLE, ISSUE, SETUP, ACCESS, DONE);
  - `ARB_MAX_REQ = 4`.
- The only sub-module is apb_rr_picker. It is combinational and maps req_valid and the pointer to a one-hot winner, with the fixed-priority variant selected under the macro.

## Test plan
- Single read, requester 0, addr 0x1000_2004, zero-wait slave returning 0xDEAD_BEEF: m_transfer pulses at N+1, req_done[0] at N+4, req_rdata = 0xDEAD_BEEF.
- Simultaneous req_valid = 2'b11 held, round robin: grants alternate 0,1,0,1. With `APB_ARB_FIXED_PRIO_EN`, requester 0 wins every time until it drops.
- Write from requester 1, wdata 0x1234_5678, slave with 3 wait states: m_addr, m_wdata and m_write stay stable from ISSUE to DONE; req_done[1] at N+7; req_rdata = 0.
- m_ready held high through SETUP: no early completion, req_done still at N+4.
- PRESETn asserted during ACCESS: all outputs are 0 next cycle, no req_done, and the pointer is 0. A new request after reset completes normally.
- NUM_REQ = 4 with all requests held for 8 transfers: grant order 0,1,2,3,0,1,2,3, confirming pointer wrap.
